// File: rtl/intcode_io_port.sv
// intcode_io_port: memory-mapped input/output FIFOs for the Intcode CPU system bus.
// The CPU pops host-supplied words from IN_ADDR, pushes results to OUT_ADDR and
// reads/clears sticky error flags at STAT_ADDR. Multi-cycle bus accesses are
// counted once each by edge-detecting the selects against their previous value.
module intcode_io_port #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] IN_ADDR   = 32'hFFFF0000,
    parameter logic [31:0] OUT_ADDR  = 32'hFFFF0001,
    parameter logic [31:0] STAT_ADDR = 32'hFFFF0002
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              address_bus,
    inout  wire  [31:0]              data_bus,
    input  logic                     ram_write,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     underflow,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // FIFO storage and bookkeeping
    logic [31:0]   r_in_mem  [DEPTH];
    logic [31:0]   r_out_mem [DEPTH];
    logic [PW-1:0] r_in_wr_ptr;
    logic [PW-1:0] r_in_rd_ptr;
    logic [PW-1:0] r_in_count;
    logic [PW-1:0] r_out_wr_ptr;
    logic [PW-1:0] r_out_rd_ptr;
    logic [PW-1:0] r_out_count;

    // Sticky flags and select history for access edge detection
    logic r_underflow;
    logic r_overflow;
    logic r_prev_rsel_in;
    logic r_prev_wsel_out;
    logic r_prev_wsel_st;

    // Bus decode
    logic w_rsel_in;
    logic w_rsel_st;
    logic w_wsel_out;
    logic w_wsel_st;

    // FIFO state and per-edge events
    logic        w_in_empty;
    logic        w_in_full;
    logic        w_out_empty;
    logic        w_out_full;
    logic [31:0] w_in_head;
    logic        w_host_push;
    logic        w_cpu_pop;
    logic        w_uf_set;
    logic        w_wr_lead;
    logic        w_cpu_push;
    logic        w_of_set;
    logic        w_host_pop;
    logic        w_st_clr;

    // Bus drive
    logic        w_bus_en;
    logic [31:0] w_status;
    logic [31:0] w_bus_val;

    assign w_rsel_in  = (address_bus == IN_ADDR)   && !ram_write;
    assign w_rsel_st  = (address_bus == STAT_ADDR) && !ram_write;
    assign w_wsel_out = (address_bus == OUT_ADDR)  &&  ram_write;
    assign w_wsel_st  = (address_bus == STAT_ADDR) &&  ram_write;

    assign w_in_empty  = (r_in_count  == '0);
    assign w_in_full   = (r_in_count  == PW'(DEPTH));
    assign w_out_empty = (r_out_count == '0);
    assign w_out_full  = (r_out_count == PW'(DEPTH));
    assign w_in_head   = r_in_mem[r_in_rd_ptr[AW-1:0]];

    // Host push has no pass-through when full; CPU pop lands on the trailing edge
    // of a read so the head stays on the bus for the whole access.
    assign w_host_push = in_valid && !w_in_full;
    assign w_cpu_pop   = r_prev_rsel_in && !w_rsel_in && !w_in_empty;
    assign w_uf_set    = w_rsel_in && !r_prev_rsel_in && w_in_empty;

    // CPU write is captured once, on the leading edge of the access.
    assign w_wr_lead   = w_wsel_out && !r_prev_wsel_out;
    assign w_cpu_push  = w_wr_lead && !w_out_full;
    assign w_of_set    = w_wr_lead && w_out_full;
    assign w_host_pop  = out_ready && !w_out_empty;
    assign w_st_clr    = w_wsel_st && !r_prev_wsel_st;

    assign w_status  = {26'd0, r_overflow, r_underflow, w_out_full, w_out_empty,
                        w_in_full, w_in_empty};
    assign w_bus_en  = w_rsel_in || w_rsel_st;
    assign w_bus_val = w_rsel_in ? (w_in_empty ? 32'd0 : w_in_head) : w_status;
    assign data_bus  = w_bus_en ? w_bus_val : {32{1'bz}};

    assign in_ready  = !w_in_full;
    assign out_valid = !w_out_empty;
    assign out_data  = r_out_mem[r_out_rd_ptr[AW-1:0]];
    assign in_count  = r_in_count;
    assign out_count = r_out_count;
    assign underflow = r_underflow;
    assign overflow  = r_overflow;

    // FIFO storage writes; contents are deliberately left uncleared by reset
    always_ff @(posedge clock) begin
        if (w_host_push) begin
            r_in_mem[r_in_wr_ptr[AW-1:0]] <= in_data;
        end
        if (w_cpu_push) begin
            r_out_mem[r_out_wr_ptr[AW-1:0]] <= data_bus;
        end
    end

    // Input FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_wr_ptr <= '0;
            r_in_rd_ptr <= '0;
            r_in_count  <= '0;
        end else begin
            if (w_host_push) begin
                r_in_wr_ptr <= r_in_wr_ptr + PW'(1);
            end
            if (w_cpu_pop) begin
                r_in_rd_ptr <= r_in_rd_ptr + PW'(1);
            end
            r_in_count <= r_in_count + PW'(w_host_push) - PW'(w_cpu_pop);
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_wr_ptr <= '0;
            r_out_rd_ptr <= '0;
            r_out_count  <= '0;
        end else begin
            if (w_cpu_push) begin
                r_out_wr_ptr <= r_out_wr_ptr + PW'(1);
            end
            if (w_host_pop) begin
                r_out_rd_ptr <= r_out_rd_ptr + PW'(1);
            end
            r_out_count <= r_out_count + PW'(w_cpu_push) - PW'(w_host_pop);
        end
    end

    // Select history and sticky flags; a set on the same edge beats a clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev_rsel_in  <= 1'b0;
            r_prev_wsel_out <= 1'b0;
            r_prev_wsel_st  <= 1'b0;
            r_underflow     <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_prev_rsel_in  <= w_rsel_in;
            r_prev_wsel_out <= w_wsel_out;
            r_prev_wsel_st  <= w_wsel_st;
            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end else if (w_st_clr) begin
                r_underflow <= 1'b0;
            end
            if (w_of_set) begin
                r_overflow <= 1'b1;
            end else if (w_st_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_intcode_io_port.sv
// Bench for intcode_io_port: queue-based reference model of the two FIFOs and
// sticky flags, driven by directed and randomized bus/host traffic.
module tb_intcode_io_port;

    localparam int unsigned DEPTH     = 16;
    localparam logic [31:0] IN_ADDR   = 32'hFFFF0000;
    localparam logic [31:0] OUT_ADDR  = 32'hFFFF0001;
    localparam logic [31:0] STAT_ADDR = 32'hFFFF0002;
    localparam logic [31:0] IDLE_ADDR = 32'h00000010;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_bus;
    logic        ram_write;
    logic [31:0] cpu_wdata;
    wire  [31:0] data_bus;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  in_count;
    logic [4:0]  out_count;
    logic        underflow;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_in_q[$];
    logic [31:0] m_out_q[$];
    bit          m_uf, m_of;
    bit          m_in_rd, m_out_wr, m_st_wr;

    assign data_bus = ram_write ? cpu_wdata : {32{1'bz}};

    always #5 clock = ~clock;

    intcode_io_port #(
        .DEPTH(DEPTH), .IN_ADDR(IN_ADDR), .OUT_ADDR(OUT_ADDR), .STAT_ADDR(STAT_ADDR)
    ) dut (
        .clock(clock), .reset(reset), .address_bus(address_bus), .data_bus(data_bus),
        .ram_write(ram_write), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_count(in_count), .out_count(out_count), .underflow(underflow), .overflow(overflow)
    );

    task automatic model_reset();
        m_in_q.delete();
        m_out_q.delete();
        m_uf = 0; m_of = 0;
        m_in_rd = 0; m_out_wr = 0; m_st_wr = 0;
    endtask

    function automatic logic [31:0] exp_status();
        int ni = m_in_q.size();
        int no = m_out_q.size();
        return {26'd0, m_of, m_uf, no == DEPTH, no == 0, ni == DEPTH, ni == 0};
    endfunction

    // One clock: evaluate the access rules on the pre-edge inputs, then advance the model.
    task automatic step();
        bit          rst_now = reset;
        bit          rd_in   = (address_bus == IN_ADDR)   && !ram_write;
        bit          wr_out  = (address_bus == OUT_ADDR)  &&  ram_write;
        bit          wr_st   = (address_bus == STAT_ADDR) &&  ram_write;
        bit          in_e    = (m_in_q.size() == 0);
        bit          in_f    = (m_in_q.size() == DEPTH);
        bit          out_e   = (m_out_q.size() == 0);
        bit          out_f   = (m_out_q.size() == DEPTH);
        bit          push_h  = in_valid;
        logic [31:0] hdata   = in_data;
        logic [31:0] wdata   = cpu_wdata;
        bit          pop_h   = out_ready;
        bit          read_begins, read_ends, write_begins, clear;
        logic [31:0] tmp;
        read_begins  = rd_in && !m_in_rd;
        read_ends    = !rd_in && m_in_rd;
        write_begins = wr_out && !m_out_wr;
        clear        = wr_st && !m_st_wr;
        @(posedge clock);
        #1;
        if (!rst_now && !reset) begin
            if (read_ends && !in_e) tmp = m_in_q.pop_front();
            if (push_h && !in_f) m_in_q.push_back(hdata);
            if (pop_h && !out_e) tmp = m_out_q.pop_front();
            if (write_begins && !out_f) m_out_q.push_back(wdata);
            if (read_begins && in_e) m_uf = 1;
            else if (clear) m_uf = 0;
            if (write_begins && out_f) m_of = 1;
            else if (clear) m_of = 0;
            m_in_rd = rd_in; m_out_wr = wr_out; m_st_wr = wr_st;
        end
    endtask

    task automatic bus_idle();
        address_bus = IDLE_ADDR;
        ram_write   = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] val, input int hold);
        address_bus = addr; ram_write = 1'b1; cpu_wdata = val;
        repeat (hold) step();
        bus_idle();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        cpu_wdata = '0; in_data = '0; in_valid = 0; out_ready = 0;
        model_reset();
        step(); step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        n_checks++;
        if (in_count !== 5'd0 || out_count !== 5'd0) begin
            n_fail++; $display("FAIL reset_counts: in=%0d out=%0d exp 0/0", in_count, out_count);
        end
        n_checks++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: uf=%b of=%b exp 0/0", underflow, overflow);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_cpu_read();
        logic [31:0] vals[3] = '{32'd7, 32'd11, 32'd13};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = vals[i];
            step();
        end
        in_valid = 0;
        n_checks++;
        if (in_count !== 5'd3) begin
            n_fail++; $display("FAIL read_fill_count: got %0d exp 3", in_count);
        end
        for (int i = 0; i < 3; i++) begin
            address_bus = IN_ADDR; ram_write = 0;
            for (int c = 0; c < 4; c++) begin
                step();
                n_checks++;
                if (data_bus !== vals[i] || data_bus !== m_in_q[0]) begin
                    n_fail++; $display("FAIL read_head[%0d] cyc%0d: got %0d exp %0d", i, c, data_bus, vals[i]);
                end
            end
            bus_idle();
            step();
            n_checks++;
            if (in_count !== 5'(2 - i) || in_count !== 5'(m_in_q.size())) begin
                n_fail++; $display("FAIL read_pop_count[%0d]: got %0d exp %0d", i, in_count, 2 - i);
            end
        end
        n_checks++;
        if (underflow !== 1'b0) begin
            n_fail++; $display("FAIL read_no_underflow: got %b exp 0", underflow);
        end
    endtask

    task automatic test_cpu_write();
        cpu_write(OUT_ADDR, 32'd42, 2);
        n_checks++;
        if (out_count !== 5'd1 || out_data !== 32'd42 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL write_capture: count=%0d data=%0d valid=%b exp 1/42/1", out_count, out_data, out_valid);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        n_checks++;
        if (out_valid !== 1'b0 || out_count !== 5'd0) begin
            n_fail++; $display("FAIL write_host_pop: valid=%b count=%0d exp 0/0", out_valid, out_count);
        end
    endtask

    task automatic test_underflow();
        address_bus = IN_ADDR; ram_write = 0;
        step(); step();
        n_checks++;
        if (data_bus !== 32'd0 || underflow !== 1'b1 || in_count !== 5'd0) begin
            n_fail++; $display("FAIL empty_read: bus=%0h uf=%b count=%0d exp 0/1/0", data_bus, underflow, in_count);
        end
        address_bus = STAT_ADDR;
        step();
        n_checks++;
        if (data_bus !== exp_status() || data_bus[0] !== 1'b1 || data_bus[4] !== 1'b1) begin
            n_fail++; $display("FAIL status_read: got %0h exp %0h", data_bus, exp_status());
        end
        n_checks++;
        if (in_count !== 5'd0) begin
            n_fail++; $display("FAIL empty_read_nopop: got %0d exp 0", in_count);
        end
        bus_idle();
        step();
        cpu_write(STAT_ADDR, 32'd0, 2);
        n_checks++;
        if (underflow !== 1'b0) begin
            n_fail++; $display("FAIL underflow_clear: got %b exp 0", underflow);
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= DEPTH + 1; k++) cpu_write(OUT_ADDR, 32'(k), 2);
        n_checks++;
        if (overflow !== 1'b1 || out_count !== 5'd16 || out_count !== 5'(m_out_q.size())) begin
            n_fail++; $display("FAIL overflow_full: of=%b count=%0d exp 1/16", overflow, out_count);
        end
        out_ready = 1;
        for (int k = 1; k <= DEPTH; k++) begin
            n_checks++;
            if (out_data !== 32'(k) || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain[%0d]: data=%0d valid=%b exp %0d/1", k, out_data, out_valid, k);
            end
            step();
        end
        out_ready = 0;
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL drain_end: valid=%b of=%b exp 0/1", out_valid, overflow);
        end
        cpu_write(STAT_ADDR, 32'd0, 1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_clear: got %b exp 0", overflow);
        end
    endtask

    task automatic test_wrap_random();
        logic [31:0] sent[40];
        int n_sent = 0, rd_idx = 0, hold = 0, cyc = 0;
        bit reading = 0, bus_bad = 0, cnt_bad = 0;
        while ((n_sent < 40 || m_in_q.size() > 0 || reading) && cyc < 4000) begin
            cyc++;
            in_valid = (n_sent < 40) && ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            if (in_valid && m_in_q.size() < DEPTH) begin
                sent[n_sent] = in_data;
                n_sent++;
            end
            if (reading && hold == 0) begin
                bus_idle(); reading = 0; rd_idx++;
            end else if (!reading && m_in_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                address_bus = IN_ADDR; ram_write = 0; reading = 1;
                hold = $urandom_range(1, 3);
            end
            step();
            if (reading) begin
                hold--;
                n_checks++;
                if (data_bus !== sent[rd_idx]) begin
                    n_fail++; bus_bad = 1;
                    $display("FAIL wrap_order[%0d]: got %0h exp %0h", rd_idx, data_bus, sent[rd_idx]);
                end
            end
            n_checks++;
            if (in_count !== 5'(m_in_q.size()) || in_ready !== (m_in_q.size() != DEPTH)) begin
                n_fail++; cnt_bad = 1;
                $display("FAIL wrap_count: count=%0d ready=%b exp %0d", in_count, in_ready, m_in_q.size());
            end
            if (bus_bad && cnt_bad) break;
        end
        in_valid = 0;
        n_checks++;
        if (cyc >= 4000 || rd_idx != 40) begin
            n_fail++; $display("FAIL wrap_done: cycles=%0d popped=%0d exp 40", cyc, rd_idx);
        end
        bus_idle();
        step();
    endtask

    task automatic test_reset_mid_read();
        in_valid = 1; in_data = 32'd7; step();
        in_data = 32'd8; step();
        in_valid = 0;
        address_bus = IN_ADDR; ram_write = 0;
        step();
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (in_count !== 5'd0 || out_count !== 5'd0 || underflow !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_clear: in=%0d out=%0d uf=%b of=%b exp 0", in_count, out_count, underflow, overflow);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_hs: ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        step();
        reset = 1'b0;
        in_valid = 1; in_data = 32'd5;
        step();
        in_valid = 0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (data_bus !== 32'd5 || in_count !== 5'd1) begin
                n_fail++; $display("FAIL post_reset_read[%0d]: bus=%0d count=%0d exp 5/1", c, data_bus, in_count);
            end
            step();
        end
        bus_idle();
        step();
        n_checks++;
        if (in_count !== 5'd0 || in_count !== 5'(m_in_q.size()) || underflow !== m_uf) begin
            n_fail++; $display("FAIL post_reset_pop: count=%0d uf=%b exp 0/%b", in_count, underflow, m_uf);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_underflow();
        test_overflow();
        test_wrap_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intcode_io_port.md
# intcode_io_port

Memory-mapped I/O responder for the Intcode CPU system bus. It replaces the fixed-value input stub and the simulation-only output printer with buffered hardware. The CPU reads input words from a host-filled input FIFO and writes output words into a host-drained output FIFO. It sits on the shared address/data/ram_write bus alongside the RAM and exposes valid/ready streams toward a host or testbench.

## Interface
- DEPTH, 16: entries per FIFO; power of two, minimum 2.
- IN_ADDR, 32'hFFFF0000: bus address of the input data port (read).
- OUT_ADDR, 32'hFFFF0001: bus address of the output data port (write).
- STAT_ADDR, 32'hFFFF0002: status register; read returns status, write clears sticky flags.

- clock  input  1  bus clock, same as the RAM clock.
- reset  input  1  asynchronous, active-high.
- address_bus  input  32  CPU address.
- data_bus  inout  32  shared data bus; driven only while this block is selected for a read.
- ram_write  input  1  bus write strobe; high means the CPU drives data_bus.
- in_data  input  32  host word to enqueue.
- in_valid  input  1  host push request.
- in_ready  output  1  input FIFO not full.
- out_data  output  32  head of the output FIFO.
- out_valid  output  1  output FIFO not empty.
- out_ready  input  1  host pop acknowledge.
- in_count  output  $clog2(DEPTH)+1  input FIFO occupancy.
- out_count  output  $clog2(DEPTH)+1  output FIFO occupancy.
- underflow  output  1  sticky: CPU read IN_ADDR while the input FIFO was empty.
- overflow  output  1  sticky: CPU wrote OUT_ADDR while the output FIFO was full.

## Operation
- Selects: rsel_in = (address_bus==IN_ADDR && !ram_write); rsel_st = (address_bus==STAT_ADDR && !ram_write); wsel_out = (address_bus==OUT_ADDR && ram_write); wsel_st = (address_bus==STAT_ADDR && ram_write).
- data_bus drive is combinational:
  - rsel_in: the input FIFO head, or 32'd0 if empty.
  - rsel_st: {26'd0, overflow, underflow, out full, out empty, in full, in empty} (bit0 = in empty).
  - Otherwise high-Z.
- Every bus access is counted once per contiguous run of cycles with the select high. The CPU holds address and strobe for several clocks. Registered prev_rsel_in and prev_wsel_out provide edge detection.
- Input pop happens at the first clock edge where rsel_in is low and prev_rsel_in is high (trailing edge). The head therefore stays stable for the whole access.
  - If the FIFO was empty during the access, there is no pop and underflow is set at the leading edge.
- Output push happens at the first clock edge where wsel_out is high and prev_wsel_out is low (leading edge). data_bus is captured into the output FIFO.
  - If the FIFO is full, the word is dropped and overflow is set.
- wsel_st leading edge clears underflow and overflow. A set event on the same edge wins.
- Host push: in_valid && in_ready at a clock edge enqueues in_data. in_ready = !in_full, with no same-cycle pass-through when full.
- Host pop: out_valid && out_ready at a clock edge dequeues. out_data = mem[rd_ptr], combinational from storage.
- Each FIFO has DEPTH words and pointers of $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty; indices wrap modulo DEPTH.
- Each FIFO accepts a push and a pop on the same edge: the count is unchanged and both pointers advance.

## Timing
- Reset (asynchronous) clears pointers, counts, underflow, overflow, prev_rsel_in and prev_wsel_out.
- Output values during reset: in_ready=1, out_valid=0, in_count=0, out_count=0, flags 0, data_bus high-Z unless a read select is active. FIFO storage is not cleared.
- Reset mid-access: after release, a select that is still high counts as a new access, because prev is 0.
- Host push to CPU visibility: a word pushed at edge N is on data_bus from N+ (combinational) if the FIFO was empty.
- CPU write to host visibility: a word captured at edge N gives out_valid=1 and out_data valid after N.
- Push into an empty FIFO with a simultaneous pop attempt: the pop is ignored because empty is evaluated before the edge. The push lands.

## Test plan
- Host pushes 7, 11, 13. CPU reads IN_ADDR three times, each held 4 cycles. Required: data_bus shows 7, 11, 13 in order, stable across each hold; in_count goes 3→0; one pop per access.
- CPU writes 42 to OUT_ADDR with ram_write held 2 cycles. Required: out_count=1, out_data=42, no duplicate. Host pops with out_ready. Required: out_valid=0.
- Empty read: CPU reads IN_ADDR with the FIFO empty. Required: data_bus=0, underflow=1, in_count stays 0, status read returns bit0=1 and bit4=1.
- Full output: perform DEPTH+1 writes of 1..17 with DEPTH=16. Required: overflow=1, out_count=16, host drains 1..16. A write to STAT_ADDR clears overflow.
- Wrap and simultaneous traffic: run 40 words through the input FIFO while host push and CPU pop overlap on the same edges. Required: order preserved, in_count never exceeds 16, in_ready low exactly when count=16.
- Assert reset mid-read with address held at IN_ADDR. Required: all counts 0 and flags 0 immediately. After release, with a pushed word 5, the held access returns 5 and pops once when the address leaves.
